// File: rtl/sd_word_gearbox.sv
// sd_word_gearbox: 8-bit SD byte stream <-> 512-bit crypto word.
// RX packs 64 bytes into word_out; TX serialises word_in into 64 bytes.
//
// Ports (rst is synchronous, active low):
//   clk, rst                         clock and reset
//   rx_byte/_valid/_ready            SD-side input bytes
//   rx_flush                         drop partial RX word
//   rx_count                         bytes held, 0..BYTES
//   word_out/_valid, word_out_ack    packed word to crypto stage
//   word_in/_valid/_ready            result word from crypto stage
//   tx_byte/_valid/_ready            SD-side output bytes
module sd_word_gearbox #(
  parameter  int DATA_WIDTH = 512,
  parameter  int BYTE_WIDTH = 8,
  localparam int BYTES      = DATA_WIDTH / BYTE_WIDTH,
  localparam int CW         = $clog2(BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_WIDTH-1:0] rx_byte,
  input  logic                  rx_byte_valid,
  output logic                  rx_byte_ready,
  input  logic                  rx_flush,
  output logic [CW-1:0]         rx_count,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_out_valid,
  input  logic                  word_out_ack,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_in_valid,
  output logic                  word_in_ready,
  output logic [BYTE_WIDTH-1:0] tx_byte,
  output logic                  tx_byte_valid,
  input  logic                  tx_byte_ready
);

  typedef enum logic {
    RX_FILL,
    RX_FULL
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  rx_state_e             rx_state_q;
  logic [CW-1:0]         rx_cnt_q;
  logic [DATA_WIDTH-1:0] rx_word_q;

  tx_state_e             tx_state_q;
  logic [CW-1:0]         tx_idx_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;

  // Flush drops ready so no byte is taken in a flush cycle.
  assign rx_byte_ready  = rst && (rx_state_q == RX_FILL)
                          && !rx_flush;
  assign word_out_valid = (rx_state_q == RX_FULL);
  assign rx_count       = rx_cnt_q;
  assign word_out       = rx_word_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q <= RX_FILL;
      rx_cnt_q   <= '0;
      rx_word_q  <= '0;
    end else begin
      unique case (rx_state_q)
        RX_FILL: begin
          if (rx_flush) begin
            rx_cnt_q  <= '0;
            rx_word_q <= '0;
          end else if (rx_byte_valid) begin
            rx_word_q[rx_cnt_q * BYTE_WIDTH +: BYTE_WIDTH]
              <= rx_byte;
            rx_cnt_q <= rx_cnt_q + ONE;
            if (rx_cnt_q == LAST) begin
              rx_state_q <= RX_FULL;
            end
          end
        end
        RX_FULL: begin
          // Flush is ignored here; only the ack frees the word.
          if (word_out_ack) begin
            rx_state_q <= RX_FILL;
            rx_cnt_q   <= '0;
            rx_word_q  <= '0;
          end
        end
        default: rx_state_q <= RX_FILL;
      endcase
    end
  end

  // The latched word shifts down, so byte 0 of what is
  // left always sits in the low lane.
  assign word_in_ready = rst && (tx_state_q == TX_IDLE);
  assign tx_byte_valid = (tx_state_q == TX_SEND);
  assign tx_byte       = tx_byte_valid
                         ? tx_shift_q[BYTE_WIDTH-1:0]
                         : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (word_in_valid) begin
            tx_shift_q <= word_in;
            tx_idx_q   <= '0;
            tx_state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_byte_ready) begin
            tx_shift_q <= tx_shift_q >> BYTE_WIDTH;
            tx_idx_q   <= tx_idx_q + ONE;
            if (tx_idx_q == LAST) begin
              tx_state_q <= TX_IDLE;
              tx_idx_q   <= '0;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_word_gearbox.sv
// tb_sd_word_gearbox: randomized scoreboard bench for sd_word_gearbox.
// Queue-level model predicts handshakes, counts and words each cycle.
module tb_sd_word_gearbox;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic         rx_byte_valid = 1'b0;
  logic         rx_byte_ready;
  logic         rx_flush = 1'b0;
  logic [6:0]   rx_count;
  logic [511:0] word_out;
  logic         word_out_valid;
  logic         word_out_ack = 1'b0;
  logic [511:0] word_in = '0;
  logic         word_in_valid = 1'b0;
  logic         word_in_ready;
  logic [7:0]   tx_byte;
  logic         tx_byte_valid;
  logic         tx_byte_ready = 1'b0;

  sd_word_gearbox dut (
    .clk            (clk),
    .rst            (rst),
    .rx_byte        (rx_byte),
    .rx_byte_valid  (rx_byte_valid),
    .rx_byte_ready  (rx_byte_ready),
    .rx_flush       (rx_flush),
    .rx_count       (rx_count),
    .word_out       (word_out),
    .word_out_valid (word_out_valid),
    .word_out_ack   (word_out_ack),
    .word_in        (word_in),
    .word_in_valid  (word_in_valid),
    .word_in_ready  (word_in_ready),
    .tx_byte        (tx_byte),
    .tx_byte_valid  (tx_byte_valid),
    .tx_byte_ready  (tx_byte_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name,
                              logic [511:0] act,
                              logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endfunction

  // Reference model: bytes held so far, completed words,
  // and the bytes still owed on the TX side.
  logic [7:0]   rxq[$];
  logic [511:0] exp_rx[$];
  logic [7:0]   txq[$];
  logic [511:0] cur_word = '0;
  bit           m_full = 0;
  bit           m_busy = 0;
  bit           m_rstd = 0;
  bit           prev_wov = 0;

  function automatic logic [511:0] pack_rx();
    logic [511:0] p = '0;
    foreach (rxq[i]) p[8*i +: 8] = rxq[i];
    return p;
  endfunction

  always @(negedge clk) begin
    int n;
    n = m_full ? 64 : rxq.size();
    chk("rx_count", 512'(rx_count), 512'(n));
    chk("rx_ready", 512'(rx_byte_ready),
        512'(rst && !m_full && !rx_flush));
    chk("word_out_valid", 512'(word_out_valid), 512'(m_full));
    if (word_out_valid && !prev_wov) begin
      if (exp_rx.size() == 0) fail_now("rx_scoreboard_empty");
      else cur_word = exp_rx.pop_front();
    end
    prev_wov = word_out_valid;
    chk("word_out", word_out, m_full ? cur_word : pack_rx());
    chk("word_in_ready", 512'(word_in_ready),
        512'(rst && !m_busy));
    chk("tx_valid", 512'(tx_byte_valid), 512'(m_busy));
    if (m_busy && txq.size() > 0)
      chk("tx_byte", 512'(tx_byte), 512'(txq[0]));
    if (m_rstd) chk("tx_byte_rst", 512'(tx_byte), '0);
    m_rstd = 0;
    if (!rst) begin
      rxq.delete();
      exp_rx.delete();
      txq.delete();
      m_full = 0;
      m_busy = 0;
      m_rstd = 1;
    end else begin
      if (m_full) begin
        if (word_out_ack) begin
          m_full = 0;
          rxq.delete();
        end
      end else if (rx_flush) begin
        rxq.delete();
      end else if (rx_byte_valid) begin
        rxq.push_back(rx_byte);
        if (rxq.size() == 64) begin
          exp_rx.push_back(pack_rx());
          m_full = 1;
        end
      end
      if (!m_busy) begin
        if (word_in_valid) begin
          for (int k = 0; k < 64; k++)
            txq.push_back(word_in[8*k +: 8]);
          m_busy = 1;
        end
      end else if (tx_byte_ready) begin
        void'(txq.pop_front());
        if (txq.size() == 0) m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_rx(input logic [7:0] b);
    bit ok = 0;
    rx_byte = b;
    rx_byte_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = rx_byte_ready;
      tick();
    end
    rx_byte_valid = 1'b0;
    if (!ok) fail_now("rx_accept");
  endtask

  task automatic send_word(input logic [511:0] w);
    bit ok = 0;
    word_in = w;
    word_in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = word_in_ready;
      tick();
    end
    word_in_valid = 1'b0;
    if (!ok) fail_now("word_accept");
  endtask

  task automatic wait_wov();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (word_out_valid) ok = 1;
      else tick();
    end
    if (!ok) fail_now("word_out_valid_wait");
  endtask

  task automatic pulse_ack();
    word_out_ack = 1'b1;
    tick();
    word_out_ack = 1'b0;
  endtask

  task automatic tx_random_drain();
    bit ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tx_byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = word_in_ready;
      tick();
    end
    tx_byte_ready = 1'b0;
    if (!ok) fail_now("tx_drain");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] w;
    logic [511:0] a5;
    logic [7:0]   e;
    int n;
    bit ok;

    // Reset with traffic offered on the RX side.
    rx_byte = 8'h77;
    rx_byte_valid = 1'b1;
    repeat (3) tick();
    chk("rst_rx_ready", 512'(rx_byte_ready), '0);
    chk("rst_win_ready", 512'(word_in_ready), '0);
    chk("rst_rx_count", 512'(rx_count), '0);
    chk("rst_word_out", word_out, '0);
    rx_byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_rx_ready", 512'(rx_byte_ready), 512'(1));
    chk("rel_win_ready", 512'(word_in_ready), 512'(1));
    tick();

    // Full word 0x00..0x3F, then a blocked 65th byte.
    for (int i = 0; i < 64; i++) send_rx(8'(i));
    chk("t2_valid_lat", 512'(word_out_valid), 512'(1));
    chk("t2_lo_byte", 512'(word_out[7:0]), 512'(8'h00));
    chk("t2_hi_byte", 512'(word_out[511:504]), 512'(8'h3F));
    chk("t2_count", 512'(rx_count), 512'(64));
    rx_byte = 8'h40;
    rx_byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t2_blocked", 512'(rx_byte_ready), '0);
      tick();
    end
    pulse_ack();
    chk("t2_ready_after_ack", 512'(rx_byte_ready), 512'(1));
    send_rx(8'h40);
    for (int i = 0; i < 9; i++) send_rx(8'($urandom));

    // Flush with valid held, then a word of 0xA5.
    rx_flush = 1'b1;
    rx_byte_valid = 1'b1;
    @(negedge clk);
    chk("t3_flush_ready", 512'(rx_byte_ready), '0);
    tick();
    rx_flush = 1'b0;
    rx_byte_valid = 1'b0;
    chk("t3_flush_count", 512'(rx_count), '0);
    for (int i = 0; i < 64; i++) send_rx(8'hA5);
    wait_wov();
    a5 = {64{8'hA5}};
    chk("t3_word_a5", word_out, a5);
    pulse_ack();

    // TX with alternating backpressure.
    for (int k = 0; k < 64; k++) w[8*k +: 8] = 8'hC0 + 8'(k);
    send_word(w);
    tx_byte_ready = 1'b1;
    n = 0;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (tx_byte_valid && tx_byte_ready) begin
        e = 8'hC0 + 8'(n);
        chk("t4_seq", 512'(tx_byte), 512'(e));
        n++;
      end
      tick();
      if (n == 64) ok = 1;
      else tx_byte_ready = ~tx_byte_ready;
    end
    tx_byte_ready = 1'b0;
    if (!ok) fail_now("t4_tx_done");
    chk("t4_win_ready_back", 512'(word_in_ready), 512'(1));
    chk("t4_tx_valid_off", 512'(tx_byte_valid), '0);

    // Concurrent traffic, then reset mid-transfer.
    fork
      begin
        for (int i = 0; i < 20; i++) send_rx(8'($urandom));
      end
      begin
        int c = 0;
        send_word(rand512());
        tx_byte_ready = 1'b1;
        for (int i = 0; i < 200 && c < 30; i++) begin
          @(negedge clk);
          if (tx_byte_valid && tx_byte_ready) c++;
          tick();
        end
        tx_byte_ready = 1'b0;
        if (c != 30) fail_now("t5_tx_30");
      end
    join
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    chk("t5_rx_count", 512'(rx_count), '0);
    chk("t5_tx_valid", 512'(tx_byte_valid), '0);
    fork
      begin
        for (int i = 0; i < 64; i++) send_rx(8'($urandom));
        wait_wov();
        pulse_ack();
      end
      begin
        send_word(rand512());
        tx_random_drain();
      end
    join

    // Flush ignored when full; ack+flush consumes once.
    for (int i = 0; i < 64; i++) send_rx(8'($urandom));
    wait_wov();
    rx_flush = 1'b1;
    tick();
    rx_flush = 1'b0;
    chk("t6_flush_full", 512'(word_out_valid), 512'(1));
    word_out_ack = 1'b1;
    rx_flush = 1'b1;
    tick();
    word_out_ack = 1'b0;
    rx_flush = 1'b0;
    chk("t6_consumed", 512'(word_out_valid), '0);
    chk("t6_count0", 512'(rx_count), '0);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) send_rx(8'($urandom));
    pulse_ack();
    chk("t6_stray_ack", 512'(rx_count), 512'(5));
    rx_flush = 1'b1;
    tick();
    rx_flush = 1'b0;
    repeat (3) tick();
    chk("end_rx_queue", 512'(exp_rx.size()), '0);
    chk("end_tx_queue", 512'(txq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
